// File: rtl/y_sram_update_writer.sv
// Read-modify-write engine that applies change records (row, col, complex delta) to the Y SRAM.
// Define YWR_SATURATE_EN to saturate add-mode results; otherwise additions wrap mod 2^24.
module y_sram_update_writer #(
  parameter int N_DIM    = 64,
  parameter int LOG2_WPR = 4,
  parameter int ADDR_W   = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              chg_valid,
  output logic              chg_ready,
  input  logic [15:0]       chg_row,
  input  logic [15:0]       chg_col,
  input  logic [23:0]       chg_real,
  input  logic [23:0]       chg_img,
  input  logic              chg_replace,
  output logic [ADDR_W-1:0] ysram_rdAddr,
  input  logic [255:0]      ysram_rdData,
  output logic              ysram_we,
  output logic [ADDR_W-1:0] ysram_wrAddr,
  output logic [255:0]      ysram_wrData,
  output logic              upd_done,
  output logic [15:0]       upd_count,
  output logic              err_flag
);

  localparam int          DATA_W  = 24;
  localparam int          SLOT_W  = 64;
  localparam logic [15:0] DIM_LIM = 16'(N_DIM);

  typedef enum logic [1:0] {IDLE, READ, CAPT, WRITE} state_t;

  state_t state, stateNext;

  logic                     accept;
  logic                     inRange;
  logic [ADDR_W-1:0]        addrCalc;

  logic [1:0]               slot_p0;
  logic signed [DATA_W-1:0] dRe_p0;
  logic signed [DATA_W-1:0] dIm_p0;
  logic                     replace_p0;

  logic signed [DATA_W-1:0] oldRe;
  logic signed [DATA_W-1:0] oldIm;
  logic signed [DATA_W-1:0] newRe;
  logic signed [DATA_W-1:0] newIm;
  logic [255:0]             newWord_p1;

  function automatic logic signed [DATA_W-1:0] addPart(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
`ifdef YWR_SATURATE_EN
    logic signed [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    // Sign-extension bits disagree only when the 24-bit result overflowed.
    if (sum[DATA_W] != sum[DATA_W-1])
      addPart = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      addPart = sum[DATA_W-1:0];
`else
    addPart = a + b;
`endif
  endfunction

  function automatic logic [SLOT_W-1:0] packSlot(
    input logic signed [DATA_W-1:0] re,
    input logic signed [DATA_W-1:0] im
  );
    packSlot = {16'h0000, re, im};
  endfunction

  assign chg_ready = (state == IDLE);
  assign ysram_we  = (state == WRITE);
  assign upd_done  = (state == WRITE);
  assign accept    = chg_valid && (state == IDLE);
  assign inRange   = (chg_row < DIM_LIM) && (chg_col < DIM_LIM);
  assign addrCalc  = (ADDR_W'(chg_row) << LOG2_WPR) + ADDR_W'(chg_col[15:2]);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && inRange) stateNext = READ;
      READ:    stateNext = CAPT;
      CAPT:    stateNext = WRITE;
      WRITE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      err_flag  <= 1'b0;
      upd_count <= 16'h0000;
    end else begin
      state <= stateNext;
      if (accept && !inRange)
        err_flag <= 1'b1;
      if (state == WRITE && upd_count != 16'hFFFF)
        upd_count <= upd_count + 16'h0001;
    end
  end

  // Stage p0: record latched at accept; read address presented during READ
  always_ff @(posedge clock) begin
    if (reset)
      ysram_rdAddr <= '0;
    else if (accept && inRange)
      ysram_rdAddr <= addrCalc;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      slot_p0    <= chg_col[1:0];
      dRe_p0     <= chg_real;
      dIm_p0     <= chg_img;
      replace_p0 <= chg_replace;
    end
  end

  // Stage p1: merge the updated slot into the word read back during CAPT
  always_comb begin
    oldRe      = '0;
    oldIm      = '0;
    newWord_p1 = ysram_rdData;
    for (int k = 0; k < 4; k++) begin
      if (slot_p0 == 2'(k)) begin
        oldRe = ysram_rdData[k*SLOT_W+DATA_W +: DATA_W];
        oldIm = ysram_rdData[k*SLOT_W +: DATA_W];
      end
    end
    newRe = replace_p0 ? dRe_p0 : addPart(oldRe, dRe_p0);
    newIm = replace_p0 ? dIm_p0 : addPart(oldIm, dIm_p0);
    for (int k = 0; k < 4; k++) begin
      if (slot_p0 == 2'(k))
        newWord_p1[k*SLOT_W +: SLOT_W] = packSlot(newRe, newIm);
    end
  end

  // Stage p2: registered write port, held between writes
  always_ff @(posedge clock) begin
    if (reset) begin
      ysram_wrAddr <= '0;
      ysram_wrData <= '0;
    end else if (state == CAPT) begin
      ysram_wrAddr <= ysram_rdAddr;
      ysram_wrData <= newWord_p1;
    end
  end

endmodule

// File: tb/tb_y_sram_update_writer.sv
// Randomized self-checking bench for y_sram_update_writer against a matrix-level SRAM model.
module tb_y_sram_update_writer;

  localparam int N    = 64;
  localparam int WPR  = N / 4;
  localparam int AW   = 11;

  logic          clock = 1'b0;
  logic          reset;
  logic          chg_valid;
  logic          chg_ready;
  logic [15:0]   chg_row;
  logic [15:0]   chg_col;
  logic [23:0]   chg_real;
  logic [23:0]   chg_img;
  logic          chg_replace;
  logic [AW-1:0] ysram_rdAddr;
  logic [255:0]  ysram_rdData;
  logic          ysram_we;
  logic [AW-1:0] ysram_wrAddr;
  logic [255:0]  ysram_wrData;
  logic          upd_done;
  logic [15:0]   upd_count;
  logic          err_flag;

  y_sram_update_writer #(.N_DIM(N), .LOG2_WPR(4), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .chg_valid(chg_valid), .chg_ready(chg_ready),
    .chg_row(chg_row), .chg_col(chg_col),
    .chg_real(chg_real), .chg_img(chg_img), .chg_replace(chg_replace),
    .ysram_rdAddr(ysram_rdAddr), .ysram_rdData(ysram_rdData),
    .ysram_we(ysram_we), .ysram_wrAddr(ysram_wrAddr), .ysram_wrData(ysram_wrData),
    .upd_done(upd_done), .upd_count(upd_count), .err_flag(err_flag)
  );

  always #5 clock = ~clock;

  // SRAM behavioural model with a registered read and a preload port
  logic [255:0]  mem [0:2047];
  logic          preWe;
  logic [AW-1:0] preAddr;
  logic [255:0]  preData;

  always @(posedge clock) begin
    ysram_rdData <= mem[ysram_rdAddr];
    if (preWe)
      mem[preAddr] <= preData;
    else if (ysram_we)
      mem[ysram_wrAddr] <= ysram_wrData;
  end

  logic [255:0] refMem [0:2047];
  logic [15:0]  refCount;
  logic         refErr;
  logic [255:0] lastWr;
  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int addr, input logic [255:0] data);
    preAddr = AW'(addr);
    preData = data;
    preWe   = 1'b1;
    @(posedge clock); #1;
    preWe   = 1'b0;
    refMem[addr] = data;
  endtask

  function automatic logic [23:0] refAdd(input logic [23:0] a, input logic [23:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef YWR_SATURATE_EN
    if (s > 8388607)  s = 8388607;
    if (s < -8388608) s = -8388608;
`endif
    return 24'(s);
  endfunction

  // Matrix element (row, col) lives in word row*WPR + col/4, slot col%4
  task automatic modelApply(input int row, input int col, input logic [23:0] re,
                            input logic [23:0] im, input logic rep,
                            output logic [AW-1:0] addr, output logic [255:0] word);
    int a;
    int k;
    logic [23:0] nr;
    logic [23:0] ni;
    a    = row * WPR + col / 4;
    k    = col % 4;
    word = refMem[a];
    nr   = rep ? re : refAdd(word[64*k+24 +: 24], re);
    ni   = rep ? im : refAdd(word[64*k +: 24], im);
    word[64*k +: 64] = {16'h0000, nr, ni};
    refMem[a] = word;
    addr = AW'(a);
  endtask

  task automatic runRec(input int row, input int col, input logic [23:0] re,
                        input logic [23:0] im, input logic rep);
    logic [AW-1:0] eAddr;
    logic [255:0]  eWord;
    chg_row     = 16'(row);
    chg_col     = 16'(col);
    chg_real    = re;
    chg_img     = im;
    chg_replace = rep;
    chg_valid   = 1'b1;
    @(posedge clock); #1;
    chg_valid = 1'b0;
    if (row >= N || col >= N) begin
      refErr = 1'b1;
      checkVal("oor_err", err_flag, 1'b1);
      checkVal("oor_ready", chg_ready, 1'b1);
      checkVal("oor_we", ysram_we, 1'b0);
      checkVal("oor_count", upd_count, refCount);
    end else begin
      modelApply(row, col, re, im, rep, eAddr, eWord);
      checkVal("read_ready", chg_ready, 1'b0);
      checkVal("read_addr", ysram_rdAddr, eAddr);
      checkVal("read_we", ysram_we, 1'b0);
      @(posedge clock); #1;
      checkVal("capt_ready", chg_ready, 1'b0);
      checkVal("capt_we", ysram_we, 1'b0);
      @(posedge clock); #1;
      checkVal("write_ready", chg_ready, 1'b0);
      checkVal("write_we", ysram_we, 1'b1);
      checkVal("write_done", upd_done, 1'b1);
      checkVal("write_addr", ysram_wrAddr, eAddr);
      checkVal("write_data", ysram_wrData, eWord);
      lastWr = ysram_wrData;
      @(posedge clock); #1;
      if (refCount != 16'hFFFF) refCount++;
      checkVal("idle_ready", chg_ready, 1'b1);
      checkVal("idle_we", ysram_we, 1'b0);
      checkVal("idle_done", upd_done, 1'b0);
      checkVal("idle_count", upd_count, refCount);
      checkVal("idle_err", err_flag, refErr);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_ready"}, chg_ready, 1'b1);
    checkVal({tag, "_we"}, ysram_we, 1'b0);
    checkVal({tag, "_done"}, upd_done, 1'b0);
    checkVal({tag, "_count"}, upd_count, 16'h0000);
    checkVal({tag, "_err"}, err_flag, 1'b0);
    checkVal({tag, "_rdaddr"}, ysram_rdAddr, '0);
    checkVal({tag, "_wraddr"}, ysram_wrAddr, '0);
    checkVal({tag, "_wrdata"}, ysram_wrData, '0);
  endtask

  initial begin
    logic [255:0] w;
    logic [23:0]  expOvf;
    reset = 1'b1;
    chg_valid = 1'b0; chg_row = '0; chg_col = '0;
    chg_real = '0; chg_img = '0; chg_replace = 1'b0;
    preWe = 1'b0; preAddr = '0; preData = '0;
    refCount = '0; refErr = 1'b0; lastWr = '0;

    for (int i = 0; i < N * WPR; i++) begin
      for (int j = 0; j < 8; j++) w[32*j +: 32] = $urandom;
      preload(i, w);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    checkResetState("reset");

    // Replace into word 0, pre-loaded with all ones
    preload(0, {256{1'b1}});
    runRec(0, 0, 24'h000123, 24'hFFFFFF, 1'b1);
    checkVal("replace_word", lastWr, {{192{1'b1}}, 64'h0000_000123_FFFFFF});

    // Add into row 2 col 5: address 33, slot 1
    w = refMem[33];
    w[127:64] = {16'h0000, 24'd100, -24'sd5};
    preload(33, w);
    runRec(2, 5, 24'd20, 24'd10, 1'b0);
    checkVal("add_slot1", lastWr[127:64], 64'h0000_000078_000005);
    checkVal("add_others", {lastWr[255:128], lastWr[63:0]}, {w[255:128], w[63:0]});

    // Back-to-back adds to one element starting from zero
    w = refMem[7 * WPR + 2];
    w[127:64] = '0;
    preload(7 * WPR + 2, w);
    runRec(7, 9, 24'd1, 24'd1, 1'b0);
    runRec(7, 9, 24'd1, 24'd1, 1'b0);
    checkVal("b2b_real", mem[7 * WPR + 2][64+24 +: 24], 24'd2);

    runRec(64, 3, 24'd7, 24'd7, 1'b0);
    runRec(3, 64, 24'd7, 24'd7, 1'b1);

    // Overflow of the real part at the positive limit
    w = refMem[5 * WPR];
    w[191:128] = {16'h0000, 24'h7FFFFF, 24'h000000};
    preload(5 * WPR, w);
    runRec(5, 2, 24'd1, 24'd0, 1'b0);
`ifdef YWR_SATURATE_EN
    expOvf = 24'h7FFFFF;
`else
    expOvf = 24'h800000;
`endif
    checkVal("ovf_real", lastWr[128+24 +: 24], expOvf);

    // Reset while in CAPT drops the record
    chg_row = 16'd10; chg_col = 16'd10; chg_real = 24'h00ABCD;
    chg_img = 24'h001234; chg_replace = 1'b1; chg_valid = 1'b1;
    @(posedge clock); #1;
    chg_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    refCount = '0;
    refErr = 1'b0;
    checkResetState("midreset");
    @(posedge clock); #1;
    checkVal("midreset_nowrite_we", ysram_we, 1'b0);
    checkVal("midreset_mem", mem[10 * WPR + 2], refMem[10 * WPR + 2]);
    runRec(10, 10, 24'h00ABCD, 24'h001234, 1'b1);

    for (int n = 0; n < 40; n++) begin
      runRec(int'($urandom_range(0, 67)), int'($urandom_range(0, 67)),
             24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8; i++) begin
      int a;
      a = int'($urandom_range(0, N * WPR - 1));
      checkVal("final_mem", mem[a], refMem[a]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
